wbu_stage: RTL and testbench
============================

// Module: wbu_stage
// PURPOSE
// Write-back stage directly downstream of the memory-access stage. Accepts one completed instruction
// per valid/ready handshake and selects the result (ALU or load data). It then either writes the
// register file, or takes a precise trap on a load/store access fault. Finally it hands the next
// fetch PC to the IFU, closing the multicycle loop, and maintains retire and latency counters.
// PARAMETERS
// XLEN         32        datapath width
// RF_ADDR_W    5         register index width (x0 hard-wired zero)
// CNT_W        64        width of cycle and minstret counters
// PORTS
// clk                  in   1        clock
// reset                in   1        async active-high reset
// mem_valid            in   1        MEM output valid
// wb_ready             out  1        WB can accept (handshake = mem_valid & wb_ready at posedge)
// mem_rdata            in   XLEN     aligned/extended load data from MEM
// alu_result           in   XLEN     EX result carried through MEM
// rd                   in   RF_ADDR_W destination register
// reg_write            in   1        instruction writes rd
// mem_to_reg           in   1        1: rd <= mem_rdata, 0: rd <= alu_result
// pc, next_pc          in   XLEN     PC of instruction / sequential-or-branch successor
// load_access_fault    in   1        load bus error
// store_access_fault   in   1        store bus error
// mem_fault_addr       in   XLEN     faulting address
// mtvec                in   XLEN     trap vector from CSR file
// mem_inst_type        in   32       instruction class tag
// mem_start_cycle      in   32       fetch-start cycle stamp
// rf_we                out  1        register-file write enable (1-cycle pulse)
// rf_waddr             out  RF_ADDR_W write index
// rf_wdata             out  XLEN     write data
// csr_trap_we          out  1        1-cycle pulse: write mepc/mcause/mtval
// csr_mepc, csr_mtval  out  XLEN     trap PC / faulting address
// csr_mcause           out  XLEN     5 = load access fault, 7 = store access fault
// wb_valid             out  1        next fetch PC valid to IFU
// ifu_ready            in   1        IFU accepts PC (handshake = wb_valid & ifu_ready)
// wb_next_pc           out  XLEN     next fetch PC (next_pc, or mtvec on trap)
// cycle_cnt, minstret  out  CNT_W    free-running cycles / retired (non-trapping) instructions
// BEHAVIOUR
// - Reset: state IDLE; wb_ready=1; rf_we=0, csr_trap_we=0, wb_valid=0; all data outputs 0; counters 0.
// - All outputs are registered. States:
//   - IDLE: wb_ready=1. On handshake, latch all inputs, wb_ready<=0.
//     Go to TRAP if either fault is set, else to COMMIT.
//   - COMMIT: rf_we=1 for exactly this cycle iff reg_write && rd!=0. rf_wdata = mem_to_reg ? mem_rdata : alu_result.
//     minstret += 1. wb_next_pc <= next_pc. Go to NOTIFY.
//   - TRAP: csr_trap_we=1 for exactly this cycle. mepc=pc, mtval=fault addr.
//     mcause=5 if load fault (load wins if both set), else 7. rf_we stays 0, minstret unchanged.
//     wb_next_pc <= mtvec. Go to NOTIFY.
//   - NOTIFY: wb_valid=1, wb_next_pc stable. When ifu_ready is sampled high, next cycle: wb_valid=0,
//     wb_ready=1, state IDLE.
// - Latency: handshake edge N -> rf_we/csr_trap_we high in cycle N+1 -> wb_valid high from N+2
//   -> wb_ready high again at earliest N+3. Throughput is 1 instruction per 3 cycles minimum.
// - The latency report (DPI, VERILATOR only) fires on the IFU handshake with mem_inst_type and
//   cycle_cnt[31:0] - mem_start_cycle (mod 2^32).
// - cycle_cnt increments every non-reset cycle. Counters wrap silently at 2^CNT_W.
// - mem_valid while wb_ready=0: ignored; MEM holds data until accepted. ifu_ready outside NOTIFY: ignored.
// - Reset mid-operation: immediate return to IDLE; any pending rf/CSR write and PC are discarded.
// - Illegal state encoding: go to IDLE with all pulses deasserted.
// STRUCTURE
// - Shared package wb_pkg: state_t enum {IDLE, COMMIT, TRAP, NOTIFY}; MCAUSE_LOAD_FAULT=5,
//   MCAUSE_STORE_FAULT=7; inst_type tag constants shared with IFU/EXU/MEM.
// - One sub-module wbu_perf_cnt: cycle_cnt and minstret with retire-increment input.
// TESTING
// 1. lw retire: rd=5, reg_write=1, mem_to_reg=1, mem_rdata=0xDEADBEEF -> rf_we pulse at N+1,
//    waddr=5, wdata=0xDEADBEEF; minstret 0->1.
// 2. x0 write: rd=0, reg_write=1, alu_result=0x1234 -> rf_we stays 0; minstret still +1;
//    wb_next_pc=next_pc.
// 3. Load fault: pc=0x80000010, fault addr=0x0F000000, mtvec=0x80000100 -> csr_trap_we pulse,
//    mcause=5, mtval=0x0F000000, wb_next_pc=0x80000100, no rf_we.
// 4. Both faults set -> mcause=5. Store fault alone -> mcause=7.
// 5. ifu_ready held low 4 cycles -> wb_valid stays high and wb_ready stays 0.
//    Release -> IDLE next cycle. A mem_valid pulse meanwhile is not accepted.
// 6. Reset asserted in COMMIT -> all outputs at reset values next sample; counters 0; no further rf_we.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared write-back definitions: widths, FSM states, trap causes and the
// instruction-class tags used across IFU/EXU/MEM/WB.
package wb_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned CNT_W     = 64;
   localparam int unsigned INST_W    = 32;
   localparam int unsigned LAT_W     = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COMMIT = 2'd1,
      TRAP   = 2'd2,
      NOTIFY = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] MCAUSE_LOAD_FAULT  = XLEN'(5);
   localparam logic [XLEN-1:0] MCAUSE_STORE_FAULT = XLEN'(7);

   localparam logic [INST_W-1:0] INST_ALU    = INST_W'(0);
   localparam logic [INST_W-1:0] INST_LOAD   = INST_W'(1);
   localparam logic [INST_W-1:0] INST_STORE  = INST_W'(2);
   localparam logic [INST_W-1:0] INST_BRANCH = INST_W'(3);
   localparam logic [INST_W-1:0] INST_JUMP   = INST_W'(4);

endpackage

// File: rtl/wbu_stage_if.sv
// MEM->WB instruction bus, WB->RF/CSR writes, WB->IFU next-PC handshake,
// counters and the per-instruction latency report.
interface wbu_stage_if;
   import wb_pkg::*;

   logic                 mem_valid;
   logic                 wb_ready;
   logic [XLEN-1:0]      mem_rdata;
   logic [XLEN-1:0]      alu_result;
   logic [RF_ADDR_W-1:0] rd;
   logic                 reg_write;
   logic                 mem_to_reg;
   logic [XLEN-1:0]      pc;
   logic [XLEN-1:0]      next_pc;
   logic                 load_access_fault;
   logic                 store_access_fault;
   logic [XLEN-1:0]      mem_fault_addr;
   logic [XLEN-1:0]      mtvec;
   logic [INST_W-1:0]    mem_inst_type;
   logic [LAT_W-1:0]     mem_start_cycle;

   logic                 rf_we;
   logic [RF_ADDR_W-1:0] rf_waddr;
   logic [XLEN-1:0]      rf_wdata;
   logic                 csr_trap_we;
   logic [XLEN-1:0]      csr_mepc;
   logic [XLEN-1:0]      csr_mtval;
   logic [XLEN-1:0]      csr_mcause;

   logic                 wb_valid;
   logic                 ifu_ready;
   logic [XLEN-1:0]      wb_next_pc;

   logic [CNT_W-1:0]     cycle_cnt;
   logic [CNT_W-1:0]     minstret;

   logic                 lat_valid;
   logic [INST_W-1:0]    lat_inst_type;
   logic [LAT_W-1:0]     lat_cycles;

   modport master (
      output mem_valid, mem_rdata, alu_result, rd, reg_write, mem_to_reg, pc, next_pc,
             load_access_fault, store_access_fault, mem_fault_addr, mtvec,
             mem_inst_type, mem_start_cycle, ifu_ready,
      input  wb_ready, rf_we, rf_waddr, rf_wdata, csr_trap_we, csr_mepc, csr_mtval,
             csr_mcause, wb_valid, wb_next_pc, cycle_cnt, minstret,
             lat_valid, lat_inst_type, lat_cycles
   );

   modport slave (
      input  mem_valid, mem_rdata, alu_result, rd, reg_write, mem_to_reg, pc, next_pc,
             load_access_fault, store_access_fault, mem_fault_addr, mtvec,
             mem_inst_type, mem_start_cycle, ifu_ready,
      output wb_ready, rf_we, rf_waddr, rf_wdata, csr_trap_we, csr_mepc, csr_mtval,
             csr_mcause, wb_valid, wb_next_pc, cycle_cnt, minstret,
             lat_valid, lat_inst_type, lat_cycles
   );

endinterface

// File: rtl/wbu_perf_cnt.sv
// Free-running cycle counter and retired-instruction counter; both wrap silently.
module wbu_perf_cnt
   import wb_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_retire,
   output logic [CNT_W-1:0] o_cycle_cnt,
   output logic [CNT_W-1:0] o_minstret
);

   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_minstret;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle_cnt <= '0;
         r_minstret  <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         if (i_retire) r_minstret <= r_minstret + CNT_W'(1);
      end
   end

   assign o_cycle_cnt = r_cycle_cnt;
   assign o_minstret  = r_minstret;

endmodule

// File: rtl/wbu_stage.sv
// Write-back stage: retires one MEM instruction per handshake into the RF or a
// precise trap, then hands the next fetch PC to the IFU.
module wbu_stage
   import wb_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   wbu_stage_if.slave bus
);

   state_t               r_state;
   logic                 r_wb_ready;
   logic                 r_rf_we;
   logic [RF_ADDR_W-1:0] r_rf_waddr;
   logic [XLEN-1:0]      r_rf_wdata;
   logic                 r_csr_trap_we;
   logic [XLEN-1:0]      r_csr_mepc;
   logic [XLEN-1:0]      r_csr_mtval;
   logic [XLEN-1:0]      r_csr_mcause;
   logic                 r_wb_valid;
   logic [XLEN-1:0]      r_wb_next_pc;
   logic [INST_W-1:0]    r_inst_type;
   logic [LAT_W-1:0]     r_start_cycle;
   logic                 r_lat_valid;
   logic [INST_W-1:0]    r_lat_inst_type;
   logic [LAT_W-1:0]     r_lat_cycles;

   logic                 w_accept;
   logic                 w_fault;
   logic                 w_retire;
   logic [CNT_W-1:0]     w_cycle_cnt;
   logic [CNT_W-1:0]     w_minstret;

   // Retirement is counted on the accepting edge so minstret moves with rf_we.
   assign w_accept = (r_state == IDLE) && r_wb_ready && bus.mem_valid;
   assign w_fault  = bus.load_access_fault || bus.store_access_fault;
   assign w_retire = w_accept && !w_fault;

   wbu_perf_cnt u_perf_cnt (
      .clk         (clk),
      .reset       (reset),
      .i_retire    (w_retire),
      .o_cycle_cnt (w_cycle_cnt),
      .o_minstret  (w_minstret)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= IDLE;
         r_wb_ready      <= 1'b1;
         r_rf_we         <= 1'b0;
         r_rf_waddr      <= '0;
         r_rf_wdata      <= '0;
         r_csr_trap_we   <= 1'b0;
         r_csr_mepc      <= '0;
         r_csr_mtval     <= '0;
         r_csr_mcause    <= '0;
         r_wb_valid      <= 1'b0;
         r_wb_next_pc    <= '0;
         r_inst_type     <= '0;
         r_start_cycle   <= '0;
         r_lat_valid     <= 1'b0;
         r_lat_inst_type <= '0;
         r_lat_cycles    <= '0;
      end else begin
         r_rf_we       <= 1'b0;
         r_csr_trap_we <= 1'b0;
         r_lat_valid   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_wb_ready    <= 1'b0;
                  r_inst_type   <= bus.mem_inst_type;
                  r_start_cycle <= bus.mem_start_cycle;
                  if (w_fault) begin
                     r_state       <= TRAP;
                     r_csr_trap_we <= 1'b1;
                     r_csr_mepc    <= bus.pc;
                     r_csr_mtval   <= bus.mem_fault_addr;
                     r_csr_mcause  <= bus.load_access_fault ? MCAUSE_LOAD_FAULT
                                                            : MCAUSE_STORE_FAULT;
                     r_wb_next_pc  <= bus.mtvec;
                  end else begin
                     r_state      <= COMMIT;
                     r_rf_we      <= bus.reg_write && (bus.rd != '0);
                     r_rf_waddr   <= bus.rd;
                     r_rf_wdata   <= bus.mem_to_reg ? bus.mem_rdata : bus.alu_result;
                     r_wb_next_pc <= bus.next_pc;
                  end
               end
            end
            COMMIT, TRAP: begin
               r_state    <= NOTIFY;
               r_wb_valid <= 1'b1;
            end
            NOTIFY: begin
               // Latency is stamped with the cycle count seen on the IFU handshake edge.
               if (bus.ifu_ready) begin
                  r_state         <= IDLE;
                  r_wb_valid      <= 1'b0;
                  r_wb_ready      <= 1'b1;
                  r_lat_valid     <= 1'b1;
                  r_lat_inst_type <= r_inst_type;
                  r_lat_cycles    <= w_cycle_cnt[LAT_W-1:0] - r_start_cycle;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_wb_ready <= 1'b1;
               r_wb_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wb_ready      = r_wb_ready;
   assign bus.rf_we         = r_rf_we;
   assign bus.rf_waddr      = r_rf_waddr;
   assign bus.rf_wdata      = r_rf_wdata;
   assign bus.csr_trap_we   = r_csr_trap_we;
   assign bus.csr_mepc      = r_csr_mepc;
   assign bus.csr_mtval     = r_csr_mtval;
   assign bus.csr_mcause    = r_csr_mcause;
   assign bus.wb_valid      = r_wb_valid;
   assign bus.wb_next_pc    = r_wb_next_pc;
   assign bus.cycle_cnt     = w_cycle_cnt;
   assign bus.minstret      = w_minstret;
   assign bus.lat_valid     = r_lat_valid;
   assign bus.lat_inst_type = r_lat_inst_type;
   assign bus.lat_cycles    = r_lat_cycles;

endmodule

// File: tb/tb_wbu_stage.sv
// Scoreboard bench for wbu_stage: directed and random instructions are pushed as
// expected retire/trap outcomes; a monitor checks them when the DUT notifies the IFU.
module tb_wbu_stage;
   import wb_pkg::*;

   typedef struct {
      logic [31:0] rdata, alu, pc, npc, faddr, mtvec, itype, start;
      logic [4:0]  rd;
      logic        reg_write, m2r, lf, sf;
   } txn_t;

   typedef struct {
      bit          trap, rf_we;
      logic [4:0]  waddr;
      logic [31:0] wdata, mcause, mepc, mtval, npc, itype, start;
      logic [63:0] minstret;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   wbu_stage_if bus();
   wbu_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));

   int          total = 0;
   int          bad = 0;
   exp_t        q[$];
   exp_t        cur;
   bit          have_cur, lat_pend, mon_en, ifu_hold;
   bit          seen_rf, seen_trap, prev_v;
   logic [4:0]  s_waddr;
   logic [31:0] s_wdata, s_mcause, s_mepc, s_mtval;
   logic [31:0] exp_lat, exp_itype;
   logic [63:0] model_ret;
   logic [63:0] tb_cyc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference cycle count: one tick per clock edge outside reset.
   always @(posedge clk or posedge reset)
      if (reset) tb_cyc <= 64'd0;
      else       tb_cyc <= tb_cyc + 64'd1;

   always @(posedge clk) begin
      #1;
      bus.ifu_ready = ifu_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
   end

   function automatic exp_t model(input txn_t t);
      exp_t e;
      e.trap   = t.lf || t.sf;
      e.rf_we  = !e.trap && t.reg_write && (t.rd != 5'd0);
      e.waddr  = t.rd;
      e.wdata  = t.m2r ? t.rdata : t.alu;
      e.mcause = t.lf ? 32'd5 : 32'd7;
      e.mepc   = t.pc;
      e.mtval  = t.faddr;
      e.npc    = e.trap ? t.mtvec : t.npc;
      e.itype  = t.itype;
      e.start  = t.start;
      e.minstret = 64'd0;
      return e;
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      t.rdata = $urandom; t.alu = $urandom; t.pc = $urandom; t.npc = $urandom;
      t.faddr = $urandom; t.mtvec = $urandom; t.start = $urandom;
      t.itype = $urandom_range(0, 4);
      t.rd = 5'($urandom);
      t.reg_write = ($urandom_range(0, 3) != 0);
      t.m2r = 1'($urandom);
      t.lf = ($urandom_range(0, 5) == 0);
      t.sf = ($urandom_range(0, 5) == 0);
      return t;
   endfunction

   task automatic drive(input txn_t t, input logic v);
      bus.mem_valid = v;
      bus.mem_rdata = t.rdata; bus.alu_result = t.alu; bus.rd = t.rd;
      bus.reg_write = t.reg_write; bus.mem_to_reg = t.m2r;
      bus.pc = t.pc; bus.next_pc = t.npc; bus.mem_fault_addr = t.faddr;
      bus.mtvec = t.mtvec; bus.mem_inst_type = t.itype; bus.mem_start_cycle = t.start;
      bus.load_access_fault = t.lf; bus.store_access_fault = t.sf;
   endtask

   // Offer t until accepted; the expectation is queued on the accepting edge.
   task automatic send(input txn_t t);
      exp_t e;
      int   g = 0;
      @(posedge clk); #1;
      drive(t, 1'b1);
      forever begin
         @(negedge clk);
         if (bus.wb_ready) break;
         g++;
         if (g > 200) begin
            chk("accept_timeout", 64'(g), 64'd0);
            bus.mem_valid = 1'b0;
            return;
         end
      end
      e = model(t);
      if (!e.trap) model_ret = model_ret + 64'd1;
      e.minstret = model_ret;
      q.push_back(e);
      @(posedge clk); #1;
      drive(rand_txn(), 1'b0);
   endtask

   task automatic wait_idle();
      int g = 0;
      while (!(q.size() == 0 && !have_cur && !lat_pend && bus.wb_ready)) begin
         @(negedge clk);
         g++;
         if (g > 500) begin
            chk("idle_timeout", 64'(g), 64'd0);
            break;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!mon_en || reset) begin
         seen_rf = 0; seen_trap = 0; prev_v = 0; have_cur = 0; lat_pend = 0;
      end else begin
         if (bus.rf_we) begin
            seen_rf = 1; s_waddr = bus.rf_waddr; s_wdata = bus.rf_wdata;
         end
         if (bus.csr_trap_we) begin
            seen_trap = 1; s_mcause = bus.csr_mcause; s_mepc = bus.csr_mepc;
            s_mtval = bus.csr_mtval;
         end
         if (bus.wb_valid && !prev_v) begin
            if (q.size() == 0) begin
               chk("notify_without_accept", 64'(bus.wb_next_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               cur = q.pop_front();
               have_cur = 1;
               chk("rf_we_pulse", 64'(seen_rf), 64'(cur.rf_we));
               if (cur.rf_we && seen_rf) begin
                  chk("rf_waddr", 64'(s_waddr), 64'(cur.waddr));
                  chk("rf_wdata", 64'(s_wdata), 64'(cur.wdata));
               end
               chk("trap_pulse", 64'(seen_trap), 64'(cur.trap));
               if (cur.trap && seen_trap) begin
                  chk("mcause", 64'(s_mcause), 64'(cur.mcause));
                  chk("mepc", 64'(s_mepc), 64'(cur.mepc));
                  chk("mtval", 64'(s_mtval), 64'(cur.mtval));
               end
               chk("pulses_single_cycle", 64'({bus.rf_we, bus.csr_trap_we}), 64'd0);
               chk("wb_next_pc", 64'(bus.wb_next_pc), 64'(cur.npc));
               chk("minstret", bus.minstret, cur.minstret);
               chk("wb_ready_in_notify", 64'(bus.wb_ready), 64'd0);
            end
            seen_rf = 0; seen_trap = 0;
         end
         if (bus.wb_valid && bus.ifu_ready && have_cur) begin
            chk("next_pc_stable", 64'(bus.wb_next_pc), 64'(cur.npc));
            exp_lat   = tb_cyc[31:0] - cur.start;
            exp_itype = cur.itype;
            lat_pend  = 1;
            have_cur  = 0;
         end else if (bus.lat_valid) begin
            if (!lat_pend) begin
               chk("lat_unexpected", 64'(bus.lat_valid), 64'd0);
            end else begin
               chk("lat_cycles", 64'(bus.lat_cycles), 64'(exp_lat));
               chk("lat_inst_type", 64'(bus.lat_inst_type), 64'(exp_itype));
               chk("idle_after_release", 64'({bus.wb_ready, bus.wb_valid}), 64'b10);
               chk("cycle_cnt", bus.cycle_cnt, tb_cyc);
            end
            lat_pend = 0;
         end
         prev_v = bus.wb_valid;
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_wb_ready"}, 64'(bus.wb_ready), 64'd1);
      chk({tag, "_pulses"}, 64'({bus.rf_we, bus.csr_trap_we, bus.wb_valid}), 64'd0);
      chk({tag, "_data"}, 64'(bus.rf_wdata | bus.wb_next_pc | bus.csr_mcause | bus.csr_mepc), 64'd0);
      chk({tag, "_cycle_cnt"}, bus.cycle_cnt, 64'd0);
      chk({tag, "_minstret"}, bus.minstret, 64'd0);
   endtask

   initial begin
      txn_t t;
      int   g;
      reset = 1'b1;
      model_ret = 64'd0;
      ifu_hold = 1'b0;
      drive(rand_txn(), 1'b0);
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      reset = 1'b0;
      mon_en = 1'b1;

      // lw retire into x5
      t = rand_txn(); t.rd = 5'd5; t.reg_write = 1; t.m2r = 1; t.rdata = 32'hDEADBEEF;
      t.lf = 0; t.sf = 0;
      send(t); wait_idle();
      // x0 write is dropped but still retires
      t = rand_txn(); t.rd = 5'd0; t.reg_write = 1; t.m2r = 0; t.alu = 32'h1234;
      t.lf = 0; t.sf = 0; t.npc = 32'h0000_0104;
      send(t); wait_idle();
      // load access fault
      t = rand_txn(); t.lf = 1; t.sf = 0; t.pc = 32'h8000_0010; t.faddr = 32'h0F00_0000;
      t.mtvec = 32'h8000_0100; t.reg_write = 1; t.rd = 5'd3;
      send(t); wait_idle();
      // both faults, then store alone
      t = rand_txn(); t.lf = 1; t.sf = 1; send(t); wait_idle();
      t = rand_txn(); t.lf = 0; t.sf = 1; send(t); wait_idle();

      // IFU stall: wb_valid held, new MEM offers ignored
      @(negedge clk); ifu_hold = 1'b1;
      t = rand_txn(); t.lf = 0; t.sf = 0; send(t);
      g = 0;
      while (!bus.wb_valid && g < 20) begin @(negedge clk); g++; end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive(rand_txn(), 1'b1);
         @(negedge clk);
         chk("stall_wb_valid", 64'(bus.wb_valid), 64'd1);
         chk("stall_wb_ready", 64'(bus.wb_ready), 64'd0);
      end
      bus.mem_valid = 1'b0;
      ifu_hold = 1'b0;
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         send(rand_txn());
         if ($urandom_range(0, 3) == 0) wait_idle();
      end
      wait_idle();

      // Reset while in COMMIT discards the pending writeback
      @(negedge clk); mon_en = 1'b0;
      t = rand_txn(); t.rd = 5'd7; t.reg_write = 1; t.lf = 0; t.sf = 0;
      send(t);
      @(negedge clk);
      chk("pre_reset_rf_we", 64'(bus.rf_we), 64'd1);
      reset = 1'b1;
      #1;
      chk_reset_vals("midreset");
      q.delete();
      model_ret = 64'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_reset_quiet", 64'({bus.rf_we, bus.wb_valid, bus.wb_ready}), 64'b001);
      end
      mon_en = 1'b1;

      for (int i = 0; i < 20; i++) send(rand_txn());
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
